mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-side consumer of the 22-bit memory address register output.
- Accepts a read or write command with MEM_ADDRESS and write data, then runs one access cycle against a wait-stated external memory (chip select, write enable, ready handshake).
- Latches read data into RDATA for the data buses and reports completion or timeout.
- Sits between the address/data registers and the memory array.

Parameters:
AW, 22, address width; matches MEM_ADDRESS.
DW, 16, data width.
TIMEOUT, 15, maximum ACCESS cycles waiting for mem_ready; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
MEM_ADDRESS  in  AW  address from the memory address register.
WDATA  in  DW  write data from the bus.
rd_req  in  1  read command, sampled in IDLE only.
wr_req  in  1  write command, sampled in IDLE only.
busy  out  1  high from the cycle after acceptance until return to IDLE.
done  out  1  one-cycle completion pulse.
err  out  1  timeout flag, valid with done, held until the next accept.
RDATA  out  DW  last successfully read data.
mem_addr  out  AW  registered address to memory.
mem_wdata  out  DW  registered write data to memory.
mem_cs  out  1  memory chip select.
mem_we  out  1  memory write enable.
mem_rdata  in  DW  memory read data.
mem_ready  in  1  memory access complete.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, err, mem_cs, mem_we = 0; RDATA, mem_addr, mem_wdata, wait counter = 0.
- Reset asserted mid-access drops mem_cs and mem_we immediately, without waiting for a clock edge.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - On an edge with rd_req or wr_req high: latch MEM_ADDRESS into mem_addr, WDATA into mem_wdata, and op into an internal register; clear err and the wait counter; go to SETUP.
  - If rd_req and wr_req are both high, read wins and op=read.
- SETUP: one cycle; mem_cs=0; address and data stable (setup time). Next edge goes to ACCESS.
- ACCESS:
  - mem_cs=1; mem_we=1 only when op=write.
  - Edge with mem_ready high: for a read, RDATA<=mem_rdata; go to DONE.
  - Edge with mem_ready low and TIMEOUT!=0 and counter==TIMEOUT-1: err<=1; RDATA unchanged; go to DONE.
  - Otherwise counter+1 and stay in ACCESS.
  - Counter width is ceil(log2(TIMEOUT+1)), minimum 1.
- DONE: done=1 and busy=1 for exactly one cycle; mem_cs=0, mem_we=0. Next edge goes to IDLE.
- busy = (state != IDLE).
- Requests while busy are ignored, not queued. The requester must hold or re-issue the request after busy falls.
- A request present on the edge that leaves DONE is not accepted. It is accepted on the following edge if still held.
- Latency: request sampled at edge E0 → ACCESS after E1 → with zero wait states, mem_ready sampled at E2 → done high in the cycle after E2.
- Each extra wait cycle adds one cycle of latency.
- Timeout case: with TIMEOUT=T, done arrives T cycles after entering ACCESS.
- mem_addr and mem_wdata hold their values after completion until the next accept.
- RDATA changes only on a successful read.

Test Plan:
1. Reset → all outputs 0. Read at addr 0x155AA, memory returns 0xBEEF with mem_ready high on the first ACCESS cycle → mem_cs high for 1 cycle, mem_we=0, done in cycle 3 after request, RDATA=0xBEEF, err=0.
2. Write addr 0x3FFFFF, WDATA=0x1234, mem_ready delayed 4 cycles → mem_we=mem_cs=1 for 5 cycles, mem_addr=0x3FFFFF, mem_wdata=0x1234, done once, RDATA unchanged.
3. rd_req and wr_req high together at addr 0x00001 → read performed, mem_we never asserts.
4. mem_ready held low, TIMEOUT=15 → mem_cs high exactly 15 cycles, then done=1 with err=1, RDATA retains previous 0xBEEF. err clears on the next accepted request.
5. New wr_req pulsed during ACCESS of a read → ignored: one done, no write cycle. Request held through DONE → accepted one cycle after IDLE is reached.
6. rst_n pulled low mid-ACCESS between edges → mem_cs, busy, RDATA go to 0 immediately. After release, the next read completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Runs a single read or write cycle against a wait-stated external memory.
// A command is accepted only in IDLE. The unit then holds the address and
// write data stable for one SETUP cycle and asserts chip select in ACCESS
// until mem_ready arrives or the wait budget runs out. DONE is a one-cycle
// completion pulse.
// Memory strobes and status flags are decoded directly from the state
// register. An asynchronous reset therefore drops mem_cs and mem_we at once,
// without waiting for a clock edge.
module mem_access_unit #(
    parameter int AW      = 22,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] MEM_ADDRESS,
    input  logic [DW-1:0] WDATA,
    input  logic          rd_req,
    input  logic          wr_req,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] RDATA,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_cs,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    // Wait counter wide enough to reach TIMEOUT; one bit when the timeout is disabled
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic          op_wr_reg, op_wr_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          err_reg, err_next;
    logic [DW-1:0] rdata_reg, rdata_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [DW-1:0] wdata_reg, wdata_next;

    logic accept;
    logic timeout_hit;

    assign accept      = (state_reg == S_IDLE) && (rd_req || wr_req);
    assign timeout_hit = TIMEOUT_EN && (cnt_reg == CNT_LAST);

    // Next-state and datapath update logic; every register holds by default
    always_comb begin
        state_next = state_reg;
        op_wr_next = op_wr_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        rdata_next = rdata_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    addr_next  = MEM_ADDRESS;
                    wdata_next = WDATA;
                    op_wr_next = ~rd_req;       // read wins when both are high
                    err_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                state_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    if (!op_wr_reg) begin
                        rdata_next = mem_rdata;
                    end
                    state_next = S_DONE;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                // Requests seen on this edge are deliberately not accepted
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            op_wr_reg <= 1'b0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            op_wr_reg <= op_wr_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            rdata_reg <= rdata_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);
    assign mem_cs    = (state_reg == S_ACCESS);
    assign mem_we    = (state_reg == S_ACCESS) && op_wr_reg;
    assign err       = err_reg;
    assign RDATA     = rdata_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: table-driven transactions against a small
// wait-stated memory model, plus hand-written multi-cycle corner cases.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic [21:0] MEM_ADDRESS;
    logic [15:0] WDATA;
    logic        rd_req;
    logic        wr_req;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] RDATA;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_cs;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    int total = 0;
    int bad   = 0;

    // Memory model control: ready arrives on ACCESS cycle ready_delay+1 (-1 = never)
    int ready_delay = 0;
    int acc_k       = 0;

    mem_access_unit #(.AW(22), .DW(16), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MEM_ADDRESS(MEM_ADDRESS),
        .WDATA      (WDATA),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .RDATA      (RDATA),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait-stated memory: counts chip-select cycles and raises ready on the chosen one
    always @(negedge clk) begin
        if (mem_cs) begin
            acc_k     = acc_k + 1;
            mem_ready = (ready_delay >= 0) && (acc_k == ready_delay + 1);
        end else begin
            acc_k     = 0;
            mem_ready = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command, then observe until two cycles past done (bounded)
    task automatic run_txn(input logic rd, input logic wr, input logic [21:0] a,
                           input logic [15:0] wd, input int d, input logic [15:0] md,
                           output int lat, output int cs_n, output int we_n,
                           output int dn, output logic err_v, output logic err_setup);
        ready_delay = d;
        mem_rdata   = md;
        lat = -1; cs_n = 0; we_n = 0; dn = 0; err_v = 1'b0; err_setup = 1'b1;
        @(negedge clk);
        rd_req = rd; wr_req = wr; MEM_ADDRESS = a; WDATA = wd;
        @(posedge clk);
        #1;
        rd_req = 1'b0; wr_req = 1'b0; MEM_ADDRESS = ~a; WDATA = ~wd;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) err_setup = err;
            if (mem_cs) cs_n++;
            if (mem_we) we_n++;
            if (done) begin
                dn++;
                if (lat < 0) begin
                    lat   = c;
                    err_v = err;
                end
            end
            if (lat >= 0 && c >= lat + 2) break;
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [21:0] addr;
        logic [15:0] wdata;
        int          delay;
        logic [15:0] mdata;
        int          exp_lat;
        int          exp_cs;
        int          exp_we;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, cs_n, we_n, dn;
        logic err_v, err_setup;

        vecs[0] = '{1'b1, 1'b0, 22'h155AA,  16'h0000,  0, 16'hBEEF,  3,  1,  0, 1'b0, 16'hBEEF};
        vecs[1] = '{1'b0, 1'b1, 22'h3FFFFF, 16'h1234,  4, 16'hDEAD,  7,  5,  5, 1'b0, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b0, 22'h2AAAA,  16'h0000, -1, 16'hFFFF, 17, 15,  0, 1'b1, 16'hBEEF};
        vecs[3] = '{1'b1, 1'b1, 22'h00001,  16'h5555,  1, 16'h0F0F,  4,  2,  0, 1'b0, 16'h0F0F};
        vecs[4] = '{1'b0, 1'b1, 22'h000000, 16'hFFFF, -1, 16'h1357, 17, 15, 15, 1'b1, 16'h0F0F};
        vecs[5] = '{1'b1, 1'b0, 22'h12345,  16'hA5A5, 14, 16'h8001, 17, 15,  0, 1'b0, 16'h8001};

        rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        MEM_ADDRESS = '0; WDATA = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  {31'b0, busy},   32'd0);
        chk("rst_done",  {31'b0, done},   32'd0);
        chk("rst_err",   {31'b0, err},    32'd0);
        chk("rst_cs",    {31'b0, mem_cs}, 32'd0);
        chk("rst_we",    {31'b0, mem_we}, 32'd0);
        chk("rst_rdata", {16'b0, RDATA},  32'd0);
        chk("rst_addr",  {10'b0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'b0, mem_wdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].delay,
                    vecs[i].mdata, lat, cs_n, we_n, dn, err_v, err_setup);
            $display("txn %0d rd=%0b wr=%0b addr=%h lat=%0d cs=%0d we=%0d err=%0b rdata=%h",
                     i, vecs[i].rd, vecs[i].wr, vecs[i].addr, lat, cs_n, we_n, err_v, RDATA);
            chk($sformatf("v%0d_latency", i),   lat,  vecs[i].exp_lat);
            chk($sformatf("v%0d_cs_cycles", i), cs_n, vecs[i].exp_cs);
            chk($sformatf("v%0d_we_cycles", i), we_n, vecs[i].exp_we);
            chk($sformatf("v%0d_done_count", i), dn, 1);
            chk($sformatf("v%0d_err", i),       {31'b0, err_v}, {31'b0, vecs[i].exp_err});
            chk($sformatf("v%0d_err_cleared", i), {31'b0, err_setup}, 32'd0);
            chk($sformatf("v%0d_rdata", i),     {16'b0, RDATA}, {16'b0, vecs[i].exp_rdata});
            chk($sformatf("v%0d_mem_addr", i),  {10'b0, mem_addr}, {10'b0, vecs[i].addr});
            chk($sformatf("v%0d_mem_wdata", i), {16'b0, mem_wdata}, {16'b0, vecs[i].wdata});
            chk($sformatf("v%0d_busy_after", i), {31'b0, busy}, 32'd0);
        end

        // Write request pulsed during a read ACCESS is ignored
        ready_delay = 3; mem_rdata = 16'h4242;
        dn = 0; we_n = 0;
        @(negedge clk);
        rd_req = 1'b1; MEM_ADDRESS = 22'h00777; WDATA = 16'h0101;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) dn++;
            if (mem_we) we_n++;
            if (c == 3) begin
                wr_req = 1'b1; MEM_ADDRESS = 22'h3F000; WDATA = 16'h9999;
            end
            if (c == 4) wr_req = 1'b0;
        end
        $display("txn ignore-while-busy dones=%0d we=%0d rdata=%h", dn, we_n, RDATA);
        chk("ign_done_count", dn, 1);
        chk("ign_we_cycles",  we_n, 0);
        chk("ign_rdata",      {16'b0, RDATA}, 32'h4242);
        chk("ign_mem_addr",   {10'b0, mem_addr}, 32'h00777);

        // Request held through DONE is taken one cycle after IDLE is reached
        ready_delay = 0; mem_rdata = 16'h6161;
        @(negedge clk);
        rd_req = 1'b1; MEM_ADDRESS = 22'h01010; WDATA = 16'h0000;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                wr_req = 1'b1; MEM_ADDRESS = 22'h2BEEF; WDATA = 16'hCAFE;
            end
            if (c == 3) chk("hold_first_done", {31'b0, done}, 32'd1);
            if (c == 4) chk("hold_idle_gap",   {31'b0, busy}, 32'd0);
            if (c == 5) begin
                chk("hold_accepted", {31'b0, busy}, 32'd1);
                wr_req = 1'b0;
            end
            if (c == 6) chk("hold_write_we", {31'b0, mem_we}, 32'd1);
            if (c == 7) chk("hold_second_done", {31'b0, done}, 32'd1);
        end
        $display("txn held-request addr=%h wdata=%h rdata=%h", mem_addr, mem_wdata, RDATA);
        chk("hold_mem_addr",  {10'b0, mem_addr}, 32'h2BEEF);
        chk("hold_mem_wdata", {16'b0, mem_wdata}, 32'hCAFE);
        chk("hold_rdata",     {16'b0, RDATA}, 32'h6161);

        // Asynchronous reset in the middle of ACCESS
        ready_delay = 5; mem_rdata = 16'h1111;
        @(negedge clk);
        rd_req = 1'b1; MEM_ADDRESS = 22'h0F0F0; WDATA = 16'h2222;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_pre_cs", {31'b0, mem_cs}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        $display("txn async-reset cs=%0b busy=%0b rdata=%h", mem_cs, busy, RDATA);
        chk("arst_cs",    {31'b0, mem_cs}, 32'd0);
        chk("arst_we",    {31'b0, mem_we}, 32'd0);
        chk("arst_busy",  {31'b0, busy},   32'd0);
        chk("arst_rdata", {16'b0, RDATA},  32'd0);
        chk("arst_addr",  {10'b0, mem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1'b1, 1'b0, 22'h0ABCD, 16'h0000, 0, 16'h7E57, lat, cs_n, we_n, dn, err_v, err_setup);
        $display("txn after-reset lat=%0d cs=%0d rdata=%h", lat, cs_n, RDATA);
        chk("post_latency", lat, 3);
        chk("post_cs",      cs_n, 1);
        chk("post_done",    dn, 1);
        chk("post_rdata",   {16'b0, RDATA}, 32'h7E57);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
